// File: rtl/wam_ctrl.sv
// Whack-a-mole session controller: IDLE -> COUNT -> PLAY -> OVER with second timer and high score.
// Optional difficulty ramp during PLAY is enabled by defining WAM_RAMP_EN.
module wam_ctrl #(
  parameter int TICK_DIV       = 500000,
  parameter int TICKS_PER_SEC  = 100,
  parameter int COUNTDOWN_SECS = 3,
  parameter int GAME_SECS      = 60,
  parameter int RAMP_SECS      = 15
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        btn_start,
  input  logic [1:0]  diff_sel,
  input  logic [11:0] score,
  output logic        game_clr,
  output logic [3:0]  difficulty,
  output logic        tap_en,
  output logic [1:0]  state,
  output logic [6:0]  time_left,
  output logic [11:0] high_score,
  output logic        new_high
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, PLAY = 2'd2, OVER = 2'd3} st_t;

  st_t           st, st_nxt;
  logic          btn_q;
  logic [PW-1:0] presc;
  logic [TW-1:0] tick_cnt;
  logic          start_ev, sec_bnd, last_sec;
  logic [3:0]    base_diff;

`ifdef WAM_RAMP_EN
  localparam int RW = (RAMP_SECS > 1) ? $clog2(RAMP_SECS) : 1;
  logic [RW-1:0] ramp_cnt;
`endif

  assign state = st;

  always_comb begin
    start_ev = btn_start & ~btn_q;
    sec_bnd  = (presc == PW'(TICK_DIV - 1)) && (tick_cnt == TW'(TICKS_PER_SEC - 1));
    last_sec = sec_bnd && (time_left == 7'd1);
    case (diff_sel)
      2'd0:    base_diff = 4'd2;
      2'd1:    base_diff = 4'd6;
      default: base_diff = 4'd10;
    endcase
    st_nxt = st;
    case (st)
      IDLE, OVER: if (start_ev) st_nxt = COUNT;
      COUNT:      if (last_sec) st_nxt = PLAY;
      PLAY:       if (last_sec) st_nxt = OVER;
      default:    st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      btn_q      <= 1'b1;  // a button held through reset must be released first
      game_clr   <= 1'b0;
      difficulty <= 4'd2;
      tap_en     <= 1'b0;
      time_left  <= 7'd0;
      high_score <= 12'd0;
      new_high   <= 1'b0;
      presc      <= '0;
      tick_cnt   <= '0;
`ifdef WAM_RAMP_EN
      ramp_cnt   <= '0;
`endif
    end else begin
      btn_q    <= btn_start;
      game_clr <= 1'b0;
      tap_en   <= (st_nxt == PLAY);

      if (st == COUNT || st == PLAY) begin
        if (sec_bnd) begin
          presc    <= '0;
          tick_cnt <= '0;
        end else if (presc == PW'(TICK_DIV - 1)) begin
          presc    <= '0;
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      case (st)
        IDLE, OVER: if (start_ev) begin
          difficulty <= base_diff;
          new_high   <= 1'b0;
          game_clr   <= 1'b1;
          time_left  <= 7'(COUNTDOWN_SECS);
          presc      <= '0;
          tick_cnt   <= '0;
`ifdef WAM_RAMP_EN
          ramp_cnt   <= '0;
`endif
        end
        COUNT: if (sec_bnd) begin
          time_left <= (time_left == 7'd1) ? 7'(GAME_SECS) : time_left - 7'd1;
        end
        PLAY: if (sec_bnd) begin
          time_left <= time_left - 7'd1;
          // pre-edge score is compared; a hit landing on this edge is dropped
          if (last_sec && score > high_score) begin
            high_score <= score;
            new_high   <= 1'b1;
          end
`ifdef WAM_RAMP_EN
          if (ramp_cnt == RW'(RAMP_SECS - 1)) begin
            ramp_cnt <= '0;
            if (difficulty != 4'd15) difficulty <= difficulty + 4'd1;
          end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/wam_ctrl.md
# wam_ctrl

Game-session controller for the whack-a-mole datapath. It sequences one round through idle, countdown, play and game-over. It drives the one-cycle clear and the difficulty code into the mole generator and score counter, and gates player taps to the play window. It also keeps a running second count and a session high score for the display. It sits beside the generator, hit checker and score counter at the top level, on the same 50 MHz clock.

## Interface
- `TICK_DIV`, 500000: clk cycles per tick (100 Hz at 50 MHz).
- `TICKS_PER_SEC`, 100: ticks per second.
- `COUNTDOWN_SECS`, 3: pre-round countdown length, 1..127.
- `GAME_SECS`, 60: round length, 1..127.
- `RAMP_SECS`, 15: seconds per difficulty step (used only with ramp enabled).
- `clk`  in  1  system clock; all logic on posedge.
- `clr_n`  in  1  reset; synchronous, active-low.
- `btn_start`  in  1  debounced start button, level.
- `diff_sel`  in  2  0 easy, 1 medium, 2 hard, 3 treated as hard.
- `score`  in  12  current score from the score counter, unsigned binary.
- `game_clr`  out  1  one-cycle clear pulse to the generator and score counter.
- `difficulty`  out  4  difficulty code to the generator.
- `tap_en`  out  1  high only in PLAY; top level ANDs it with `tap[7:0]`.
- `state`  out  2  0 IDLE, 1 COUNT, 2 PLAY, 3 OVER.
- `time_left`  out  7  seconds remaining in COUNT/PLAY.
- `high_score`  out  12  best score since reset.
- `new_high`  out  1  last round set a new high score.

## Operation
- Start edge: `start_ev = btn_start & ~btn_q`. `btn_q` resets to 1, so a button held through reset must be released before it can start a round.
- IDLE: on `start_ev`, latch the base difficulty (easy 4'd2, medium 4'd6, hard 4'd10), clear `new_high`, pulse `game_clr`, set `time_left = COUNTDOWN_SECS`, clear the prescaler and tick counter, and go to COUNT.
- COUNT: on each second boundary, decrement `time_left`. At a boundary with `time_left == 1`, go to PLAY, load `time_left = GAME_SECS`, and clear the prescaler and tick counter.
- PLAY: `tap_en = 1`. On each second boundary, decrement `time_left`. At a boundary with `time_left == 1`, go to OVER with `time_left = 0`. On that same edge, if `score > high_score`, load `high_score <= score` and set `new_high <= 1`.
- OVER: `score` is held by the datapath because no clear is issued. On `start_ev`, take the same actions as from IDLE and go directly to COUNT.
- `start_ev` is ignored in COUNT and PLAY.
- Second boundary: the cycle in which the prescaler equals `TICK_DIV-1` and the tick counter equals `TICKS_PER_SEC-1`. Both counters wrap to 0 at that boundary.
- `high_score` is cleared only by `clr_n`.
- Reset mid-round: all state returns to reset values on the next edge, with no `game_clr` pulse.

## Timing
- Reset values: state IDLE, `game_clr` 0, `difficulty` 4'd2, `tap_en` 0, `time_left` 0, `high_score` 0, `new_high` 0, prescaler 0, tick counter 0.
- Let S = `TICK_DIV*TICKS_PER_SEC`.
- The edge E that samples `start_ev` sets `game_clr` high for exactly the cycle after E.
- `state` = COUNT from E+1. PLAY begins COUNTDOWN_SECS·S cycles later. OVER begins GAME_SECS·S cycles after PLAY.
- All outputs are registered, with no combinational input-to-output path.
- `tap_en` rises and falls on the same edges that `state` enters and leaves PLAY.
- If the score-counter increment and the PLAY→OVER edge coincide, the value compared is the pre-edge `score`. The late hit is dropped by `tap_en` going low.

## Configuration
- `WAM_RAMP_EN` defined:
  - In PLAY, `difficulty` increments by 1 every `RAMP_SECS` second boundaries, saturating at 4'd15.
  - It returns to the latched base on the next start.
- `WAM_RAMP_EN` undefined:
  - `difficulty` stays at the latched base for the whole round.
  - No ramp counter is synthesised.

## Test plan
Bench parameters: `TICK_DIV=4`, `TICKS_PER_SEC=2`, `COUNTDOWN_SECS=2`, `GAME_SECS=3`, `RAMP_SECS=1`, so S = 8.
- Reset with `btn_start` held high, then release and press, `diff_sel=1`:
  - No start until the release.
  - On the press, `game_clr` is high for 1 cycle, `state=1`, `time_left=2`, `difficulty=6`.
- Let the round run:
  - PLAY at 16 cycles after COUNT entry, with `time_left=3` and `tap_en=1`.
  - OVER at 24 cycles after that, with `time_left=0` and `tap_en=0`.
- Drive `score=12'd40` at game end:
  - `high_score=40`, `new_high=1`.
- Next round, `score=12'd25` at end:
  - `high_score` stays 40 and `new_high=0`.
  - `new_high` cleared on the start press.
- With `WAM_RAMP_EN`, `diff_sel=2`:
  - `difficulty` goes 10, 11, 12, 13 across the PLAY seconds.
  - Without the macro it stays 10.
- Pull `clr_n` low mid-PLAY for 1 cycle:
  - Next cycle shows `state=0`, `tap_en=0`, `high_score=0`, no `game_clr`.
- Press start during COUNT and during PLAY:
  - No effect on `state`, `time_left` or `game_clr`.
